// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Pipeline MEM stage: accepts one load/store request at a time from EX/MEM,
// accesses an internal word-addressed data array after a fixed latency and
// returns a single-cycle response to MEM/WB. The upstream pipeline is held
// with stall while a request is being serviced.
//
// Parameters
//   DEPTH    number of 32-bit words in the data array (power of two, 2..65536)
//   LATENCY  edges from acceptance to the response cycle (1..15)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  request presented by EX/MEM
//   req_write  1 = store, 0 = load
//   req_addr   byte address; word index is req_addr[log2(DEPTH)+1:2]
//   req_wdata  store data
//   req_ready  request accepted this cycle when req_valid is also high
//   rsp_valid  one-cycle completion pulse (MEM/WB ready)
//   rsp_rdata  load data, zero unless a successful load is responding
//   rsp_err    misaligned-access flag, valid with rsp_valid
//   stall      hold request for PC, IF/ID, ID/EX and EX/MEM
//
// Optional build macro
//   MEM_ACCESS_WRITE_BUFFER_EN  adds a one-entry posted write buffer: aligned
//   stores complete in one cycle without stalling, the entry drains into the
//   array LATENCY cycles later, and matching loads are forwarded from it.
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [3:0]  LAT_N  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;

  // Request captured at acceptance; used while waiting in WAIT
  logic              cap_write_reg;
  logic              cap_mis_reg;
  logic [AW-1:0]     cap_idx_reg;
  logic [31:0]       cap_wdata_reg;
  logic              cap_fwd_reg;
  logic [31:0]       cap_fwd_data_reg;

  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic              rsp_load_reg;
  logic              rsp_fwd_reg;
  logic [31:0]       rsp_fwd_data_reg;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_rdata_reg;

  logic [AW-1:0]     req_idx;
  logic              req_mis;
  logic              accept;
  logic              post_store;
  logic              going_resp;

  logic              acc_write;
  logic              acc_mis;
  logic [AW-1:0]     acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_fwd;
  logic [31:0]       acc_fwd_data;

  logic              live_fwd;
  logic [31:0]       live_fwd_data;

  logic              mem_we;
  logic              mem_re;
  logic [AW-1:0]     mem_widx;
  logic [31:0]       mem_wdata;

  // Upper address bits are deliberately ignored (accesses wrap modulo DEPTH)
  logic              addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:AW+2];

  assign req_idx = req_addr[AW+1:2];
  assign req_mis = |req_addr[1:0];

  // Acceptance is gated by reset so a request seen while reset is low can
  // never move the FSM or touch the (non-reset) array.
  assign accept = req_valid && req_ready && reset;

`ifdef MEM_ACCESS_WRITE_BUFFER_EN
  logic              buf_valid_reg;
  logic [AW-1:0]     buf_idx_reg;
  logic [31:0]       buf_data_reg;
  logic [3:0]        buf_cnt_reg;
  logic              drain;

  // Any store waits while the buffer holds an entry
  assign req_ready  = (state_reg == IDLE) && !(req_write && buf_valid_reg);
  assign post_store = (state_reg == IDLE) && req_valid && req_write &&
                      !req_mis && !buf_valid_reg;
  assign stall      = ((state_reg == IDLE) && req_valid && !post_store) ||
                      (state_reg == WAIT);
  assign drain      = buf_valid_reg && (buf_cnt_reg == 4'd1);

  assign live_fwd      = buf_valid_reg && (buf_idx_reg == req_idx);
  assign live_fwd_data = buf_data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_reg <= 1'b0;
      buf_idx_reg   <= '0;
      buf_data_reg  <= '0;
      buf_cnt_reg   <= '0;
    end else if (accept && post_store) begin
      buf_valid_reg <= 1'b1;
      buf_idx_reg   <= req_idx;
      buf_data_reg  <= req_wdata;
      buf_cnt_reg   <= LAT_N;
    end else if (drain) begin
      buf_valid_reg <= 1'b0;
      buf_cnt_reg   <= '0;
    end else if (buf_valid_reg) begin
      buf_cnt_reg   <= buf_cnt_reg - 4'd1;
    end
  end

  // Only the buffer writes the array: aligned stores are always posted
  assign mem_we    = drain;
  assign mem_widx  = buf_idx_reg;
  assign mem_wdata = buf_data_reg;
`else
  assign req_ready     = (state_reg == IDLE);
  assign post_store    = 1'b0;
  assign stall         = ((state_reg == IDLE) && req_valid) || (state_reg == WAIT);
  assign live_fwd      = 1'b0;
  assign live_fwd_data = '0;

  assign mem_we    = going_resp && acc_write && !acc_mis;
  assign mem_widx  = acc_idx;
  assign mem_wdata = acc_wdata;
`endif

  // In IDLE the access happens on the acceptance edge itself (LATENCY=1 or a
  // posted store), so the live inputs are used; otherwise the captured copy.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_write    = req_write;
      acc_mis      = req_mis;
      acc_idx      = req_idx;
      acc_wdata    = req_wdata;
      acc_fwd      = live_fwd;
      acc_fwd_data = live_fwd_data;
    end else begin
      acc_write    = cap_write_reg;
      acc_mis      = cap_mis_reg;
      acc_idx      = cap_idx_reg;
      acc_wdata    = cap_wdata_reg;
      acc_fwd      = cap_fwd_reg;
      acc_fwd_data = cap_fwd_data_reg;
    end
  end

  assign going_resp = ((state_reg == IDLE) && accept && (post_store || (LATENCY == 1))) ||
                      ((state_reg == WAIT) && (cnt_reg == 4'd1));

  assign mem_re = going_resp && !acc_write && !acc_mis;

  // Data array: no reset, registered read on the edge entering RESP
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rdata_reg <= mem[acc_idx];
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      cap_write_reg    <= 1'b0;
      cap_mis_reg      <= 1'b0;
      cap_idx_reg      <= '0;
      cap_wdata_reg    <= '0;
      cap_fwd_reg      <= 1'b0;
      cap_fwd_data_reg <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_err_reg      <= 1'b0;
      rsp_load_reg     <= 1'b0;
      rsp_fwd_reg      <= 1'b0;
      rsp_fwd_data_reg <= '0;
    end else begin
      rsp_valid_reg <= going_resp;
      rsp_err_reg   <= going_resp && acc_mis;
      rsp_load_reg  <= mem_re;
      rsp_fwd_reg   <= mem_re && acc_fwd;
      if (going_resp) begin
        rsp_fwd_data_reg <= acc_fwd_data;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            cap_write_reg    <= req_write;
            cap_mis_reg      <= req_mis;
            cap_idx_reg      <= req_idx;
            cap_wdata_reg    <= req_wdata;
            // Forward decision is taken at acceptance: the entry may drain
            // before the array read, and then the array holds the same data.
            cap_fwd_reg      <= live_fwd;
            cap_fwd_data_reg <= live_fwd_data;
            if (going_resp) begin
              state_reg <= RESP;
              cnt_reg   <= '0;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_load_reg ? (rsp_fwd_reg ? rsp_fwd_data_reg : mem_rdata_reg) : 32'd0;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage (DEPTH=256, LATENCY=3). A table of
// directed load/store records with hand-computed latency, data and error
// values, followed by hand-written sequences for reset behaviour, continuous
// req_valid throughput and reset during an in-flight store.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int L = 3;
`ifdef MEM_ACCESS_WRITE_BUFFER_EN
  localparam int SL = 1;
`else
  localparam int SL = L;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  int checks = 0;
  int passed = 0;

  mem_access_stage #(.DEPTH(256), .LATENCY(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Present one request from a negedge, wait for acceptance, then count
  // edges from the acceptance edge until rsp_valid is seen.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic acc, output int lat, output logic [31:0] rd,
                        output logic err);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = req_ready;
    lat = -1;
    rd  = '0;
    err = 1'b0;
    if (acc) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          lat = k;
          rd  = rsp_rdata;
          err = rsp_err;
          break;
        end
      end
    end else begin
      req_valid = 1'b0;
    end
    $display("txn %s addr=0x%08h wdata=0x%08h lat=%0d rdata=0x%08h err=%0b",
             wr ? "ST" : "LD", addr, wdata, lat, rd, err);
  endtask

  vec_t vecs[13];

  initial begin
    logic        acc;
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          ph;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, SL, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         L,  32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, SL, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         L,  32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         L,  32'h0, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, L,  32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         L,  32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, SL, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_07FC, 32'h0,         L,  32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, SL, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         L,  32'h1111_2222, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0040, 32'h0BAD_F00D, SL, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0040, 32'h0,         L,  32'h0BAD_F00D, 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_ready",     32'(req_ready), 32'd1);
    check("rst_stall_lo",  32'(stall), 32'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h5555_5555;
    #1;
    check("rst_stall_hi",  32'(stall), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_no_leave",  32'(rsp_valid), 32'd0);
    check("rst_ready_hold", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    reset     = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, acc, lat, rd, err);
      check($sformatf("v%0d_accept", i), 32'(acc), 32'd1);
      check($sformatf("v%0d_lat", i),    32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_rdata", i),  rd, vecs[i].rdata);
      check($sformatf("v%0d_err", i),    32'(err), 32'(vecs[i].err));
    end

    // Continuous req_valid: accept every L+1 cycles, stall low only in RESP
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    #1;
    for (int i = 0; i < 4 * (L + 1); i++) begin
      ph = i % (L + 1);
      check($sformatf("bb%0d_ready", i), 32'(req_ready), (ph == 0) ? 32'd1 : 32'd0);
      check($sformatf("bb%0d_stall", i), 32'(stall),     (ph == L) ? 32'd0 : 32'd1);
      check($sformatf("bb%0d_rsp", i),   32'(rsp_valid), (ph == L) ? 32'd1 : 32'd0);
      if (ph == L) check($sformatf("bb%0d_rdata", i), rsp_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
    end
    req_valid = 1'b0;
    $display("txn back-to-back loads done");

    // Reset one cycle after accepting a store: the store is lost
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hAAAA_5555;
    #1;
    check("r39_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("r39_rsp%0d", i), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("r39_rsp_rel", 32'(rsp_valid), 32'd0);
    check("r39_err_rel", 32'(rsp_err), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, acc, lat, rd, err);
    check("r39_accept", 32'(acc), 32'd1);
    check("r39_lat",    32'(lat), 32'(L));
    check("r39_rdata",  rd, 32'h1111_2222);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
